// File: rtl/hexdisp_ctrl.sv
// hexdisp_ctrl: takes a 32-bit value from the CPU's display register and drives
// the eight seven-segment digits HEX0..HEX7 (active-low {g,f,e,d,c,b,a}).
// Decimal writes go through a bit-serial double-dabble converter; hex writes
// and out-of-range decimal writes skip straight to the display update.
// One write arriving during a conversion is held in a pending slot, newest wins.
module hexdisp_ctrl #(
   parameter int DIGITS   = 8,
   parameter int BIN_BITS = 27
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        dec_mode,
   output logic        busy,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7
);

   localparam logic [31:0] DEC_MAX    = 32'd99_999_999;
   localparam logic [4:0]  LAST_SHIFT = 5'(BIN_BITS - 1);
   localparam logic [6:0]  SEG_BLANK  = 7'h7F;
   localparam logic [6:0]  SEG_DASH   = 7'h3F;

   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

   state_t                 state;
   logic [31:0]            job_data;
   logic                   job_dec;
   logic                   job_ovf;
   logic [4*DIGITS-1:0]    bcd;
   logic [BIN_BITS-1:0]    shifter;
   logic [4:0]             count;
   logic                   pend_valid;
   logic [31:0]            pend_data;
   logic                   pend_dec;
   logic [6:0]             hex_q [DIGITS];

   logic                   start;
   logic [31:0]            start_data;
   logic                   start_dec;
   logic                   start_in_range;
   logic [4*DIGITS-1:0]    bcd_adj;
   logic [6:0]             seg_next [DIGITS];
   logic                   seen;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0:    seg7 = 7'h40;
         4'h1:    seg7 = 7'h79;
         4'h2:    seg7 = 7'h24;
         4'h3:    seg7 = 7'h30;
         4'h4:    seg7 = 7'h19;
         4'h5:    seg7 = 7'h12;
         4'h6:    seg7 = 7'h02;
         4'h7:    seg7 = 7'h78;
         4'h8:    seg7 = 7'h00;
         4'h9:    seg7 = 7'h10;
         4'hA:    seg7 = 7'h08;
         4'hB:    seg7 = 7'h03;
         4'hC:    seg7 = 7'h46;
         4'hD:    seg7 = 7'h21;
         4'hE:    seg7 = 7'h06;
         4'hF:    seg7 = 7'h0E;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // Decide whether a job starts this edge; a live write beats the pending slot
   always_comb begin
      start      = 1'b0;
      start_data = wr_data;
      start_dec  = dec_mode;
      if (state == IDLE) begin
         start = wr_en;
      end else if (state == UPDATE) begin
         if (wr_en) begin
            start = 1'b1;
         end else if (pend_valid) begin
            start      = 1'b1;
            start_data = pend_data;
            start_dec  = pend_dec;
         end
      end
      start_in_range = (start_data <= DEC_MAX);
   end

   // Double-dabble correction: bump every BCD nibble of 5 or more by 3 before the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // Digit encodings for the next update, blanking decimal leading zeros from the top down
   always_comb begin
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seg_next[i] = SEG_BLANK;
         if (job_ovf) begin
            seg_next[i] = SEG_DASH;
         end else if (!job_dec) begin
            seg_next[i] = seg7(job_data[i*4 +: 4]);
         end else begin
            if ((bcd[i*4 +: 4] != 4'd0) || (i == 0))
               seen = 1'b1;
            seg_next[i] = seen ? seg7(bcd[i*4 +: 4]) : SEG_BLANK;
         end
      end
   end

   // Sequencer: accept/queue writes, run the conversion, latch all digits at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         job_data   <= '0;
         job_dec    <= 1'b0;
         job_ovf    <= 1'b0;
         bcd        <= '0;
         shifter    <= '0;
         count      <= '0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         pend_dec   <= 1'b0;
         for (int i = 0; i < DIGITS; i++)
            hex_q[i] <= SEG_BLANK;
      end else begin
         case (state)
            IDLE: begin
            end
            SHIFT: begin
               bcd     <= {bcd_adj[4*DIGITS-2:0], shifter[BIN_BITS-1]};
               shifter <= {shifter[BIN_BITS-2:0], 1'b0};
               count   <= count + 5'd1;
               if (count == LAST_SHIFT)
                  state <= UPDATE;
               if (wr_en) begin
                  pend_valid <= 1'b1;
                  pend_data  <= wr_data;
                  pend_dec   <= dec_mode;
               end
            end
            UPDATE: begin
               for (int i = 0; i < DIGITS; i++)
                  hex_q[i] <= seg_next[i];
               pend_valid <= 1'b0;
               if (!start) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (start) begin
            job_data <= start_data;
            job_dec  <= start_dec;
            busy     <= 1'b1;
            if (start_dec && start_in_range) begin
               job_ovf <= 1'b0;
               bcd     <= '0;
               shifter <= start_data[BIN_BITS-1:0];
               count   <= '0;
               state   <= SHIFT;
            end else begin
               job_ovf <= start_dec;
               state   <= UPDATE;
            end
         end
      end
   end

   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];
   assign HEX6 = hex_q[6];
   assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hexdisp_ctrl.sv
// tb_hexdisp_ctrl: self-checking bench for hexdisp_ctrl. Each write pushes the
// expected display word and the cycle it must appear on into a scoreboard; a
// monitor after every rising edge compares updates, holds between updates, and busy.
module tb_hexdisp_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        dec_mode;
   logic        busy;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

   localparam logic [55:0] BLANK = {8{7'h7F}};

   typedef struct {
      logic [55:0] hex;
      int          due;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      logic        dec;
      logic [55:0] hex;
      int          lat;
   } vec_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [55:0] last_hex;
   logic [55:0] mon_hex;
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Free-running 100 MHz style clock
   always #5 clk = ~clk;

   hexdisp_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .dec_mode(dec_mode),
      .busy(busy),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
      .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
   );

   function automatic logic [55:0] model(input logic [31:0] d, input logic dec);
      logic [55:0]  r;
      logic [3:0]   dig [8];
      int unsigned  v;
      bit           nz;
      r = BLANK;
      if (!dec) begin
         for (int i = 0; i < 8; i++) r[i*7 +: 7] = seg_tab[d[i*4 +: 4]];
      end else if (d > 32'd99_999_999) begin
         r = {8{7'h3F}};
      end else begin
         v = d;
         for (int i = 0; i < 8; i++) begin
            dig[i] = 4'(v % 10);
            v = v / 10;
         end
         nz = 1'b0;
         for (int i = 7; i >= 0; i--) begin
            if (dig[i] != 4'd0 || i == 0) nz = 1'b1;
            r[i*7 +: 7] = nz ? seg_tab[dig[i]] : 7'h7F;
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Called at a falling edge; the write is accepted on the next rising edge
   task automatic applyStimulus(input logic [31:0] d, input logic dec, input bit do_push,
                                input logic [55:0] exp, input int lat, output int e);
      wr_en    = 1'b1;
      wr_data  = d;
      dec_mode = dec;
      e        = cyc + 1;
      if (do_push) sb.push_back('{hex: exp, due: e + lat});
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_cycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: outstanding=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: after each rising edge compare the due update or the held value, then busy
   always @(posedge clk) begin
      cyc++;
      #1;
      if (mon_en) begin
         mon_hex = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
         if (sb.size() > 0 && sb[0].due == cyc) begin
            checkOutput("update", 64'(mon_hex), 64'(sb[0].hex));
            sb.delete(0);
         end else begin
            checkOutput("hold", 64'(mon_hex), 64'(last_hex));
         end
         last_hex = mon_hex;
         checkOutput("busy", 64'(busy), 64'(sb.size() > 0));
      end
   end

   // Stimulus: reset, table vectors, random vectors, then the multi-cycle corner cases
   initial begin
      vec_t        vecs[$];
      int          e, e2;
      logic [31:0] d;
      logic        dm;

      vecs.push_back('{32'd12345, 1'b1,
                       {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 28});
      vecs.push_back('{32'hDEADBEEF, 1'b0,
                       {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}, 1});
      vecs.push_back('{32'd99_999_999, 1'b1, {8{7'h10}}, 28});
      vecs.push_back('{32'd100_000_000, 1'b1, {8{7'h3F}}, 1});
      vecs.push_back('{32'd0, 1'b1,
                       {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 28});
      vecs.push_back('{32'h0000_0000, 1'b0, {8{7'h40}}, 1});
      vecs.push_back('{32'h0123_4567, 1'b0,
                       {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, 1});
      vecs.push_back('{32'h89AB_CDEF, 1'b0,
                       {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 1});
      vecs.push_back('{32'd10_000_000, 1'b1,
                       {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 28});
      vecs.push_back('{32'hFFFF_FFFF, 1'b1, {8{7'h3F}}, 1});
      vecs.push_back('{32'd7, 1'b1,
                       {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}, 28});

      rst      = 1'b1;
      wr_en    = 1'b0;
      wr_data  = '0;
      dec_mode = 1'b0;
      last_hex = BLANK;
      #1;
      checkOutput("reset_hex", 64'({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(BLANK));
      checkOutput("reset_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].data, vecs[k].dec, 1'b1, vecs[k].hex, vecs[k].lat, e);
         wait_drain(100);
         @(negedge clk);
      end

      for (int k = 0; k < 6; k++) begin
         dm = (k < 4);
         d  = dm ? 32'($urandom_range(0, 99_999_999)) : 32'($urandom);
         applyStimulus(d, dm, 1'b1, model(d, dm), (dm && d <= 32'd99_999_999) ? 28 : 1, e);
         wait_drain(100);
         @(negedge clk);
      end

      $display("[TB] back-to-back writes 1, 2, 3");
      applyStimulus(32'd1, 1'b1, 1'b1, model(32'd1, 1'b1), 28, e);
      sb.push_back('{hex: model(32'd3, 1'b1), due: e + 56});
      wait_cycle(e + 4);
      applyStimulus(32'd2, 1'b1, 1'b0, BLANK, 0, e2);
      wait_cycle(e + 9);
      applyStimulus(32'd3, 1'b1, 1'b0, BLANK, 0, e2);
      wait_drain(200);
      @(negedge clk);

      $display("[TB] write coincident with update while pending is valid");
      applyStimulus(32'd5, 1'b1, 1'b1, model(32'd5, 1'b1), 28, e);
      wait_cycle(e + 4);
      applyStimulus(32'd6, 1'b1, 1'b0, BLANK, 0, e2);
      wait_cycle(e + 27);
      applyStimulus(32'h0000_000C, 1'b0, 1'b1, model(32'h0000_000C, 1'b0), 1, e2);
      wait_drain(200);
      @(negedge clk);

      $display("[TB] reset during conversion");
      mon_en = 1'b0;
      applyStimulus(32'd12345, 1'b1, 1'b0, BLANK, 0, e);
      wait_cycle(e + 4);
      applyStimulus(32'd99, 1'b1, 1'b0, BLANK, 0, e2);
      wait_cycle(e + 10);
      rst = 1'b1;
      #1;
      checkOutput("abort_hex", 64'({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(BLANK));
      checkOutput("abort_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst      = 1'b0;
      sb.delete();
      last_hex = BLANK;
      mon_en   = 1'b1;
      @(negedge clk);
      applyStimulus(32'd7, 1'b1, 1'b1, model(32'd7, 1'b1), 28, e);
      wait_drain(100);
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hexdisp_ctrl.md
# hexdisp_ctrl

Sequencing controller between the CPU's memory-mapped display output and the eight seven-segment displays HEX0–HEX7. It accepts a 32-bit value from the CPU with a single-cycle write strobe. In decimal mode it runs a multi-cycle shift-add-3 (double-dabble) binary-to-BCD conversion; in hex mode it bypasses the conversion. It then latches all eight digit encodings at once. A one-deep pending buffer absorbs CPU writes that arrive while a conversion is in progress, so the CPU never stalls.

## Interface
- DIGITS, 8: number of display digits (fixed; the datapath is sized for 8).
- BIN_BITS, 27: bits shifted in decimal mode (covers 99_999_999).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  single-cycle write strobe from the CPU I/O register.
- wr_data  in  32  value to display.
- dec_mode  in  1  sampled with wr_en: 1 = unsigned decimal, 0 = hexadecimal.
- busy  out  1  registered; high while a job or a pending job exists.
- HEX0..HEX7  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 is the least significant digit.

## Operation
- States:
  - IDLE: waiting for a write.
  - SHIFT: double-dabble iterations.
  - UPDATE: latch digits onto the HEX outputs.
- IDLE, wr_en=1: capture wr_data and dec_mode into the job register.
  - dec_mode=1 and wr_data ≤ 99_999_999: clear the 32-bit BCD register, load the shifter with wr_data[26:0], clear the counter, go to SHIFT.
  - dec_mode=1 and wr_data > 99_999_999: set an overflow flag, go to UPDATE.
  - dec_mode=0: go to UPDATE.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble that is ≥ 5.
  - Then shift {bcd, shifter} left by 1.
  - Counter increments. After BIN_BITS (27) iterations, go to UPDATE.
- UPDATE: write all eight HEX registers in the same edge.
  - Hex mode: nibble i of the job value drives HEXi, with all 8 digits shown.
  - Decimal mode: BCD nibble i drives HEXi. Leading zeros are blanked (7'h7F). HEX0 always shows a digit, so value 0 displays "0".
  - Overflow: all eight digits show a dash (7'h3F).
- Next-job selection on the UPDATE edge:
  - wr_en=1 that cycle: the new write starts immediately and pending is cleared (newest wins).
  - Otherwise, pending valid: the pending job starts and pending is cleared.
  - Otherwise: go to IDLE.
- Writes in SHIFT: stored in pending (data + mode). A later write overwrites it; at most one job is queued.
- Segment codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - dash = 3F, blank = 7F (all hex).

## Timing
- Reset values:
  - State IDLE; busy=0; pending cleared; counter 0.
  - HEX0..HEX7 = 7'h7F (blank).
- Reset asserted mid-job aborts immediately. HEX outputs return to blank, and the queued job is lost.
- Accept edge = E (IDLE with wr_en=1).
  - Decimal in range: SHIFT on edges E+1..E+27; HEX updated at edge E+28.
  - Hex mode or overflow: HEX updated at edge E+1.
- busy:
  - Rises at edge E and stays high through a job.
  - Falls at the UPDATE edge if no next job is selected.
  - Stays high across back-to-back jobs.
- HEX outputs change only on UPDATE edges. There are no partial or intermediate digit states.
- wr_en while busy is never dropped silently. Only an older pending entry may be overwritten by a newer one.

## Test plan
- Decimal value 12345:
  - HEX4..HEX0 = 79,24,30,19,12; HEX7..HEX5 = 7F.
  - Update exactly 28 cycles after the accept edge; busy high for those 28 cycles.
- Hex mode 0xDEADBEEF: HEX7..HEX0 = 21,06,08,21,03,06,06,0E, one cycle after accept.
- Decimal boundaries:
  - 99_999_999 → all eight digits = 10.
  - 100_000_000 → all eight = 3F after 1 cycle.
  - 0 → HEX0 = 40, others 7F.
- Back-to-back writes:
  - Write 1, then at E+5 write 2, at E+10 write 3: display goes 1 at E+28, then 3 at E+56; value 2 never appears.
  - busy stays high until E+56.
- Write coincident with the UPDATE edge while pending is valid: the coincident write wins and the pending value is discarded.
- Reset during SHIFT:
  - Assert rst at E+10: HEX = 7F and busy = 0 asynchronously.
  - After release, a write of 7 displays 78 on HEX0.
